// File: rtl/mult_div_unit_pkg.sv
// Shared types for the execute-stage multiply/divide unit.
// Opcodes, FSM states and the FIX-stage sign correction.
package mult_div_unit_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULT,
    MD_MULTU,
    MD_DIV,
    MD_DIVU
  } mdop_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_FIX,
    S_DONE
  } mdstate_t;

  // joint=1 negates the whole 2W product, else hi/lo independently
  function automatic logic [2*MD_WIDTH-1:0] negate2w(
    input logic [2*MD_WIDTH-1:0] v,
    input logic                  joint,
    input logic                  neg_hi,
    input logic                  neg_lo
  );
    logic [2*MD_WIDTH-1:0] res;
    logic [MD_WIDTH-1:0]   h;
    logic [MD_WIDTH-1:0]   l;
    h = v[2*MD_WIDTH-1:MD_WIDTH];
    l = v[MD_WIDTH-1:0];
    if (neg_hi) h = -h;
    if (neg_lo) l = -l;
    res = {h, l};
    if (joint) res = neg_hi ? -v : v;
    return res;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between execute stage and mult/div unit.
// Master is the pipeline, slave is the unit.
interface mult_div_unit_if #(
  parameter int WIDTH = mult_div_unit_pkg::MD_WIDTH
);
  import mult_div_unit_pkg::*;

  logic             start;
  mdop_t            mdop;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, mdop, rs_data, rt_data, flush,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, mdop, rs_data, rt_data, flush,
    output busy, done, hi, lo, div_by_zero
  );

endinterface

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO.
// One 2W accumulator is shared by both operations.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input logic            CLK,
  input logic            nRST,
  mult_div_unit_if.slave md
);

  localparam int CW = $clog2(WIDTH) + 1;

  mdstate_t           r_state;
  mdstate_t           w_next;
  logic               r_div;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_rs;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_dbz;

  logic               w_in_signed;
  logic               w_in_div;
  logic               w_sa;
  logic               w_sb;
  logic               w_dbz;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_rem;
  logic [WIDTH-1:0]   w_diff;
  logic [2*WIDTH-1:0] w_mul;
  logic [2*WIDTH-1:0] w_dv;
  logic [2*WIDTH-1:0] w_fix;

  assign w_in_div = (md.mdop == MD_DIV) ||
                    (md.mdop == MD_DIVU);
  assign w_in_signed = (md.mdop == MD_DIV) ||
                       (md.mdop == MD_MULT);
  assign w_sa = w_in_signed & md.rs_data[WIDTH-1];
  assign w_sb = w_in_signed & md.rt_data[WIDTH-1];
  assign w_dbz = r_div && (r_b == '0);

  always_comb begin
    w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_a};
    w_mul  = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]}
                      : {1'b0, r_acc[2*WIDTH-1:1]};
    // Shifted remainder needs one extra bit before compare
    w_rem  = r_acc[2*WIDTH-1:WIDTH-1];
    w_diff = w_rem[WIDTH-1:0] - r_b;
    if (w_rem >= {1'b0, r_b}) begin
      w_dv = {w_diff, r_acc[WIDTH-2:0], 1'b1};
    end else begin
      w_dv = {w_rem[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end
    w_fix = negate2w(r_acc, !r_div,
                     r_div ? r_neg_r : r_neg_q,
                     r_neg_q);
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (md.start) w_next = S_LOAD;
      S_LOAD: w_next = w_dbz ? S_DONE : S_RUN;
      S_RUN: begin
        if (r_count == CW'(WIDTH - 1)) w_next = S_FIX;
      end
      S_FIX:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (md.flush) w_next = S_IDLE;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_IDLE;
      r_div   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_rs    <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_acc   <= '0;
      r_count <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (md.flush) begin
        r_count <= '0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (md.start) begin
              r_div   <= w_in_div;
              r_rs    <= md.rs_data;
              r_a     <= w_sa ? -md.rs_data : md.rs_data;
              r_b     <= w_sb ? -md.rt_data : md.rt_data;
              r_neg_q <= w_sa ^ w_sb;
              r_neg_r <= w_sa;
            end
          end
          S_LOAD: begin
            r_count <= '0;
            r_acc   <= {{WIDTH{1'b0}}, r_div ? r_a : r_b};
            if (w_dbz) begin
              r_hi  <= r_rs;
              r_lo  <= '1;
              r_dbz <= 1'b1;
            end
          end
          S_RUN: begin
            r_acc   <= r_div ? w_dv : w_mul;
            r_count <= r_count + 1'b1;
          end
          S_FIX: begin
            r_hi  <= w_fix[2*WIDTH-1:WIDTH];
            r_lo  <= w_fix[WIDTH-1:0];
            r_dbz <= 1'b0;
          end
          S_DONE:  r_count <= '0;
          default: r_count <= '0;
        endcase
      end
    end
  end

  assign md.busy = (r_state == S_LOAD) ||
                   (r_state == S_RUN) ||
                   (r_state == S_FIX);
  assign md.done = (r_state == S_DONE);
  assign md.hi = r_hi;
  assign md.lo = r_lo;
  assign md.div_by_zero = r_dbz;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table plus
// flush, ignored-start and async reset sequences.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  typedef struct {
    mdop_t       op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  mult_div_unit_if bus ();

  mult_div_unit dut (
    .CLK  (clk),
    .nRST (rst_n),
    .md   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
  endtask

  // inj: cycle after accept at which a stray start is driven
  task automatic run_op(input mdop_t op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input int inj,
                        output logic [31:0] hi,
                        output logic [31:0] lo,
                        output logic dbz,
                        output int lat,
                        output logic busy1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mdop = op;
    bus.rs_data = a;
    bus.rt_data = b;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.start = 1'b0;
    busy1 = bus.busy;
    while (!bus.done && lat < 100) begin
      if (lat == inj) begin
        bus.start = 1'b1;
        bus.mdop = MD_DIVU;
        bus.rs_data = 32'd100;
        bus.rt_data = 32'd7;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    hi = bus.hi;
    lo = bus.lo;
    dbz = bus.div_by_zero;
  endtask

  vec_t        tv[11];
  logic [31:0] rh;
  logic [31:0] rl;
  logic        rd;
  logic        rb;
  int          lat;
  logic [31:0] ph;
  logic [31:0] pl;
  int          dcnt;

  initial begin
    n_chk = 0;
    n_pass = 0;
    tv[0]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'hFFFFFFFE, 32'h00000001, 1'b0, 35};
    tv[1]  = '{MD_MULT, 32'hFFFFFFF9, 32'd3,
               32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 35};
    tv[2]  = '{MD_MULT, 32'h80000000, 32'h80000000,
               32'h40000000, 32'h00000000, 1'b0, 35};
    tv[3]  = '{MD_DIV, 32'hFFFFFFF9, 32'd2,
               32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 35};
    tv[4]  = '{MD_DIVU, 32'd100, 32'd7,
               32'd2, 32'd14, 1'b0, 35};
    tv[5]  = '{MD_DIVU, 32'd5, 32'd0,
               32'd5, 32'hFFFFFFFF, 1'b1, 2};
    tv[6]  = '{MD_MULTU, 32'd6, 32'd7,
               32'd0, 32'd42, 1'b0, 35};
    tv[7]  = '{MD_DIV, 32'h80000000, 32'hFFFFFFFF,
               32'd0, 32'h80000000, 1'b0, 35};
    tv[8]  = '{MD_DIV, 32'd7, 32'hFFFFFFFE,
               32'd1, 32'hFFFFFFFD, 1'b0, 35};
    tv[9]  = '{MD_DIV, 32'hFFFFFFF8, 32'd0,
               32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1, 2};
    tv[10] = '{MD_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'd0, 32'd1, 1'b0, 35};

    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.mdop = MD_MULTU;
    bus.rs_data = '0;
    bus.rt_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_out",
        {29'd0, bus.busy, bus.done, bus.div_by_zero,
         bus.hi | bus.lo}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_op(tv[i].op, tv[i].a, tv[i].b, 0,
             rh, rl, rd, lat, rb);
      chk($sformatf("v%0d_hi", i), {32'd0, rh},
          {32'd0, tv[i].hi});
      chk($sformatf("v%0d_lo", i), {32'd0, rl},
          {32'd0, tv[i].lo});
      chk($sformatf("v%0d_dbz", i), {63'd0, rd},
          {63'd0, tv[i].dbz});
      chk($sformatf("v%0d_lat", i), 64'(lat),
          64'(tv[i].lat));
      chk($sformatf("v%0d_busy", i), {63'd0, rb}, 64'd1);
    end

    // stray start mid-run and in DONE must be ignored
    run_op(MD_MULTU, 32'd3, 32'd5, 12,
           rh, rl, rd, lat, rb);
    chk("inj_lo", {32'd0, rl}, 64'd15);
    chk("inj_hi", {32'd0, rh}, 64'd0);
    chk("inj_lat", 64'(lat), 64'd35);
    bus.start = 1'b1;
    bus.mdop = MD_DIVU;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    chk("done_start_busy", {63'd0, bus.busy}, 64'd0);

    // flush beats start in IDLE
    bus.start = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("idle_flush_busy", {63'd0, bus.busy}, 64'd0);

    // flush at RUN count=10
    ph = bus.hi;
    pl = bus.lo;
    bus.start = 1'b1;
    bus.mdop = MD_MULTU;
    bus.rs_data = 32'h1234;
    bus.rt_data = 32'h5678;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    chk("pre_flush_busy", {63'd0, bus.busy}, 64'd1);
    bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_busy", {63'd0, bus.busy}, 64'd0);
    chk("flush_done", {63'd0, bus.done}, 64'd0);
    dcnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    chk("flush_no_done", 64'(dcnt), 64'd0);
    chk("flush_keep", {bus.hi, bus.lo}, {ph, pl});

    // async reset mid-run
    bus.start = 1'b1;
    bus.mdop = MD_DIVU;
    bus.rs_data = 32'd1000;
    bus.rt_data = 32'd3;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst",
        {29'd0, bus.busy, bus.done, bus.div_by_zero,
         bus.hi | bus.lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 0,
           rh, rl, rd, lat, rb);
    chk("post_rst_lo", {32'd0, rl}, 64'h80000000);
    chk("post_rst_hi", {32'd0, rh}, 64'd0);
    chk("post_rst_dbz", {63'd0, rd}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
